// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// uart_tx_serializer: UART transmit stage. Accepts one byte per send/busy
// handshake and drives it onto TXD as start bit, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits.
// Ports:
//   i_Clk       system clock
//   i_Rst       asynchronous active-low reset
//   i_send      level request, byte on i_tx_data is valid
//   i_tx_data   byte to transmit, sampled on the accept edge only
//   o_txd       serial line, idles high (registered)
//   o_txd_busy  high from the cycle after accept until the frame completes
//   o_tx_done   one-cycle pulse when the last stop bit period ends
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_send,
  input  logic [7:0] i_tx_data,
  output logic       o_txd,
  output logic       o_txd_busy,
  output logic       o_tx_done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Illegal parity selections fall back to no parity.
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);
  // Any stop-bit count other than 2 behaves as 1.
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud, baud_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic             stop_idx, stop_idx_n;
  logic [7:0]       shift_reg, shift_reg_n;
  logic             par_bit, par_bit_n;
  logic             txd, txd_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             baud_end;

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bit_idx   <= bit_idx_n;
      stop_idx  <= stop_idx_n;
      shift_reg <= shift_reg_n;
      par_bit   <= par_bit_n;
      txd       <= txd_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic; txd_n is the line value for the
  // period that begins on the coming edge, so o_txd stays registered.
  always_comb begin
    state_n     = state;
    baud_n      = baud;
    bit_idx_n   = bit_idx;
    stop_idx_n  = stop_idx;
    shift_reg_n = shift_reg;
    par_bit_n   = par_bit;
    txd_n       = txd;
    busy_n      = busy;
    done_n      = 1'b0;
    baud_end    = (baud == BAUD_LAST);

    case (state)
      S_IDLE: begin
        txd_n  = 1'b1;
        baud_n = '0;
        if (i_send && !busy) begin
          shift_reg_n = i_tx_data;
          par_bit_n   = PAR_ODD ? ~^i_tx_data : ^i_tx_data;
          bit_idx_n   = '0;
          stop_idx_n  = 1'b0;
          txd_n       = 1'b0;
          busy_n      = 1'b1;
          state_n     = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_n  = '0;
          txd_n   = shift_reg[0];
          state_n = S_DATA;
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            if (PAR_EN) begin
              txd_n   = par_bit;
              state_n = S_PARITY;
            end else begin
              txd_n   = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            // Shift out the finished bit; the next one is shift_reg[1].
            bit_idx_n   = bit_idx + 3'd1;
            shift_reg_n = {1'b0, shift_reg[7:1]};
            txd_n       = shift_reg[1];
          end
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          baud_n  = '0;
          txd_n   = 1'b1;
          state_n = S_STOP;
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end

      S_STOP: begin
        txd_n = 1'b1;
        if (baud_end) begin
          baud_n = '0;
          if (stop_idx == STOP_LAST) begin
            stop_idx_n = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b1;
            state_n    = S_IDLE;
          end else begin
            stop_idx_n = 1'b1;
          end
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end

      default: begin
        baud_n  = '0;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign o_txd      = txd;
  assign o_txd_busy = busy;
  assign o_tx_done  = done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
// Bench for uart_tx_serializer: three instances (8N1, odd parity 2 stop,
// even parity 1 stop) checked cycle by cycle against a frame model.
module tb_uart_tx_serializer;

  localparam int unsigned NU = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send [NU];
  logic [7:0] data [NU];
  logic       txd  [NU];
  logic       busy [NU];
  logic       done [NU];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clk(clk), .i_Rst(rst_n), .i_send(send[0]), .i_tx_data(data[0]),
    .o_txd(txd[0]), .o_txd_busy(busy[0]), .o_tx_done(done[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u1 (
    .i_Clk(clk), .i_Rst(rst_n), .i_send(send[1]), .i_tx_data(data[1]),
    .o_txd(txd[1]), .o_txd_busy(busy[1]), .o_tx_done(done[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(3), .PARITY(2), .STOP_BITS(1)) u2 (
    .i_Clk(clk), .i_Rst(rst_n), .i_send(send[2]), .i_tx_data(data[2]),
    .o_txd(txd[2]), .o_txd_busy(busy[2]), .o_tx_done(done[2]));

  // ---------------- reference model ----------------
  function automatic int cpb(input int u);
    case (u)
      0: return 4;
      1: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int par_mode(input int u);
    case (u)
      0: return 0;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int stops(input int u);
    return (u == 1) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int u);
    return (9 + ((par_mode(u) != 0) ? 1 : 0) + stops(u)) * cpb(u);
  endfunction

  // Line level during bit period p of a frame carrying byte d.
  function automatic logic frame_bit(input int u, input logic [7:0] d, input int p);
    int ones;
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
    if (par_mode(u) != 0 && p == 9) begin
      ones = $countones(d);
      if (par_mode(u) == 1) return ((ones % 2) == 0) ? 1'b1 : 1'b0;
      return ((ones % 2) == 1) ? 1'b1 : 1'b0;
    end
    return 1'b1;
  endfunction

  // Present byte d (call just after a falling edge), observe the whole
  // frame plus the following cycle, and decode it with a mid-bit receiver.
  task automatic run_frame(input int u, input logic [7:0] d, input bit hold,
                           input bit chg, input logic [7:0] dnew,
                           output int line_err, output int busy_err,
                           output int busy_cycles, output int done_cnt,
                           output logic done_last, output logic [7:0] rx,
                           output logic rxp);
    int   f;
    int   c;
    logic exp_txd;
    logic exp_busy;
    f = frame_len(u);
    c = cpb(u);
    line_err = 0; busy_err = 0; busy_cycles = 0; done_cnt = 0;
    done_last = 1'b0; rx = 8'h00; rxp = 1'b0;
    data[u] = d;
    send[u] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= f + 1; k++) begin
      @(negedge clk);
      exp_txd  = (k <= f) ? frame_bit(u, d, (k - 1) / c) : 1'b1;
      exp_busy = (k <= f) ? 1'b1 : 1'b0;
      if (txd[u] !== exp_txd) line_err++;
      if (busy[u] !== exp_busy) busy_err++;
      if (busy[u] === 1'b1) busy_cycles++;
      if (done[u] === 1'b1) done_cnt++;
      if (k == f + 1) done_last = done[u];
      if (k > c && k <= 9 * c && ((k - 1) % c) == c / 2) rx[((k - 1) / c) - 1] = txd[u];
      if (par_mode(u) != 0 && ((k - 1) / c) == 9 && ((k - 1) % c) == c / 2) rxp = txd[u];
      if (k == 1 && !hold) send[u] = 1'b0;
      if (chg && k == f / 2) data[u] = dnew;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int err;
    rst_n = 1'b0;
    for (int u = 0; u < NU; u++) begin
      send[u] = 1'b0;
      data[u] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      total++;
      if (txd[u] !== 1'b1) begin bad++; $display("FAIL reset_txd u%0d: got %b want 1", u, txd[u]); end
      total++;
      if (busy[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u%0d: got %b want 0", u, busy[u]); end
      total++;
      if (done[u] !== 1'b0) begin bad++; $display("FAIL reset_done u%0d: got %b want 0", u, done[u]); end
    end
    rst_n = 1'b1;
    for (int u = 0; u < NU; u++) begin
      err = 0;
      repeat (100) begin
        @(negedge clk);
        if (txd[u] !== 1'b1 || busy[u] !== 1'b0 || done[u] !== 1'b0) err++;
      end
      total++;
      if (err !== 0) begin bad++; $display("FAIL reset_idle u%0d: got %0d bad cycles want 0", u, err); end
    end
  endtask

  task automatic test_8n1();
    int le, be, bc, dc; logic dl; logic [7:0] rx; logic rp;
    run_frame(0, 8'h55, 1'b0, 1'b0, 8'h00, le, be, bc, dc, dl, rx, rp);
    total++;
    if (le !== 0) begin bad++; $display("FAIL 8n1_line: got %0d bad cycles want 0", le); end
    total++;
    if (rx !== 8'h55) begin bad++; $display("FAIL 8n1_rx: got %h want 55", rx); end
    total++;
    if (bc !== 40 || be !== 0) begin bad++; $display("FAIL 8n1_busy: got %0d cycles (%0d off) want 40", bc, be); end
    total++;
    if (dc !== 1 || dl !== 1'b1) begin bad++; $display("FAIL 8n1_done: got %0d pulses last=%b want 1", dc, dl); end
  endtask

  task automatic test_odd_parity();
    int le, be, bc, dc; logic dl; logic [7:0] rx; logic rp;
    logic [7:0] bytes [2];
    logic       pexp  [2];
    bytes[0] = 8'h07; pexp[0] = 1'b0;
    bytes[1] = 8'h03; pexp[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_frame(1, bytes[i], 1'b0, 1'b0, 8'h00, le, be, bc, dc, dl, rx, rp);
      total++;
      if (rp !== pexp[i]) begin bad++; $display("FAIL odd_parity_bit %h: got %b want %b", bytes[i], rp, pexp[i]); end
      total++;
      if (le !== 0 || rx !== bytes[i]) begin bad++; $display("FAIL odd_line %h: got rx %h with %0d bad cycles", bytes[i], rx, le); end
      total++;
      if (bc !== 48 || be !== 0) begin bad++; $display("FAIL odd_frame_len %h: got %0d want 48", bytes[i], bc); end
      total++;
      if (dc !== 1 || dl !== 1'b1) begin bad++; $display("FAIL odd_done %h: got %0d want 1", bytes[i], dc); end
    end
  endtask

  task automatic test_back_to_back();
    int le, be, bc, dc; logic dl; logic [7:0] rx; logic rp;
    int dsum;
    logic [7:0] bytes [4];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
    dsum = 0;
    for (int i = 0; i < 4; i++) begin
      run_frame(0, bytes[i], 1'b1, 1'b0, 8'h00, le, be, bc, dc, dl, rx, rp);
      dsum += dc;
      total++;
      if (rx !== bytes[i] || le !== 0) begin bad++; $display("FAIL b2b_frame %0d: got %h (%0d bad cycles) want %h", i, rx, le, bytes[i]); end
      total++;
      if (be !== 0 || dl !== 1'b1) begin bad++; $display("FAIL b2b_gap %0d: got %0d busy errors done=%b", i, be, dl); end
    end
    send[0] = 1'b0;
    total++;
    if (dsum !== 4) begin bad++; $display("FAIL b2b_done_count: got %0d want 4", dsum); end
  endtask

  task automatic test_data_change();
    int le, be, bc, dc; logic dl; logic [7:0] rx; logic rp;
    int err;
    run_frame(0, 8'h12, 1'b0, 1'b1, 8'hEE, le, be, bc, dc, dl, rx, rp);
    total++;
    if (rx !== 8'h12 || le !== 0) begin bad++; $display("FAIL chg_frame: got %h (%0d bad cycles) want 12", rx, le); end
    err = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL chg_no_resend: got %0d active cycles want 0", err); end
    run_frame(0, 8'h12, 1'b1, 1'b1, 8'hEE, le, be, bc, dc, dl, rx, rp);
    total++;
    if (rx !== 8'h12 || le !== 0) begin bad++; $display("FAIL chg_hold_first: got %h want 12", rx); end
    run_frame(0, 8'hEE, 1'b0, 1'b0, 8'h00, le, be, bc, dc, dl, rx, rp);
    total++;
    if (rx !== 8'hEE || le !== 0 || be !== 0) begin bad++; $display("FAIL chg_hold_next: got %h want ee", rx); end
  endtask

  task automatic test_reset_mid_frame();
    int le, be, bc, dc; logic dl; logic [7:0] rx; logic rp;
    int dcnt;
    int err;
    data[0] = 8'h81;
    send[0] = 1'b1;
    @(posedge clk);
    // Bit period 4 (data bit 3) spans cycles 17..20 after accept.
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) send[0] = 1'b0;
    end
    total++;
    if (txd[0] !== 1'b0) begin bad++; $display("FAIL mid_pre_bit3: got %b want 0", txd[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (txd[0] !== 1'b1) begin bad++; $display("FAIL mid_txd_async: got %b want 1", txd[0]); end
    total++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin bad++; $display("FAIL mid_busy_done: got busy=%b done=%b want 0 0", busy[0], done[0]); end
    dcnt = 0; err = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0] === 1'b1) dcnt++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done[0] === 1'b1) dcnt++;
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) err++;
    end
    total++;
    if (dcnt !== 0 || err !== 0) begin bad++; $display("FAIL mid_discard: got %0d done pulses %0d active cycles want 0 0", dcnt, err); end
    run_frame(0, 8'h42, 1'b0, 1'b0, 8'h00, le, be, bc, dc, dl, rx, rp);
    total++;
    if (rx !== 8'h42 || le !== 0 || be !== 0 || dc !== 1) begin bad++; $display("FAIL mid_after_send: got %h (%0d line, %0d busy, %0d done)", rx, le, be, dc); end
  endtask

  task automatic test_random();
    int le, be, bc, dc; logic dl; logic [7:0] rx; logic rp;
    logic [7:0] d;
    bit hold;
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 8; i++) begin
        d    = 8'($urandom_range(0, 255));
        hold = ($urandom_range(0, 1) == 1);
        run_frame(u, d, hold, 1'b1, 8'($urandom_range(0, 255)), le, be, bc, dc, dl, rx, rp);
        total++;
        if (rx !== d || le !== 0) begin bad++; $display("FAIL rand_line u%0d: got %h (%0d bad cycles) want %h", u, rx, le, d); end
        total++;
        if (be !== 0 || dc !== 1 || dl !== 1'b1) begin bad++; $display("FAIL rand_handshake u%0d: got %0d busy errors %0d done", u, be, dc); end
        if (par_mode(u) != 0) begin
          total++;
          if (rp !== frame_bit(u, d, 9)) begin bad++; $display("FAIL rand_parity u%0d %h: got %b want %b", u, d, rp, frame_bit(u, d, 9)); end
        end
        if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      send[u] = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_8n1();
    test_odd_parity();
    test_back_to_back();
    test_data_change();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
